// File: rtl/ps2_keyboard_if.sv
// ps2_keyboard_if: PS/2 pad pins in, Hack KBD word out.
interface ps2_keyboard_if;
  logic        ps2_clk;
  logic        ps2_data;
  logic [15:0] out;
  modport master (output ps2_clk, ps2_data, input out);
  modport slave  (input ps2_clk, ps2_data, output out);
endinterface

// File: rtl/ps2_keyboard.sv
// ps2_keyboard: PS/2 set-2 receiver and decoder producing the Hack KBD word.
// Define PS2_PARITY_CHECK_EN to reject frames that fail odd parity.
module ps2_keyboard #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input logic            clk,
  input logic            reset,
  ps2_keyboard_if.slave  kbd
);
  localparam int FW = $clog2(FILTER_LEN) + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  state_t      state_q, state_d;
  logic        clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic        filt_q, filt_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [2:0]  bitcnt_q, bitcnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        par_ok_q, par_ok_d;
  logic        bv_q, bv_d;
  logic        ext_q, ext_d, brk_q, brk_d;
  logic [7:0]  out_q, out_d;
  logic        flip, fall, busy, tout, drop, parity_ok;
  logic [7:0]  code;
  function automatic logic [7:0] lut(input logic [8:0] k);
    case (k)
      9'h01C: return 8'd65;  9'h032: return 8'd66;  9'h021: return 8'd67;  9'h023: return 8'd68;
      9'h024: return 8'd69;  9'h02B: return 8'd70;  9'h034: return 8'd71;  9'h033: return 8'd72;
      9'h043: return 8'd73;  9'h03B: return 8'd74;  9'h042: return 8'd75;  9'h04B: return 8'd76;
      9'h03A: return 8'd77;  9'h031: return 8'd78;  9'h044: return 8'd79;  9'h04D: return 8'd80;
      9'h015: return 8'd81;  9'h02D: return 8'd82;  9'h01B: return 8'd83;  9'h02C: return 8'd84;
      9'h03C: return 8'd85;  9'h02A: return 8'd86;  9'h01D: return 8'd87;  9'h022: return 8'd88;
      9'h035: return 8'd89;  9'h01A: return 8'd90;
      9'h045: return 8'd48;  9'h016: return 8'd49;  9'h01E: return 8'd50;  9'h026: return 8'd51;
      9'h025: return 8'd52;  9'h02E: return 8'd53;  9'h036: return 8'd54;  9'h03D: return 8'd55;
      9'h03E: return 8'd56;  9'h046: return 8'd57;
      9'h029: return 8'd32;  9'h00E: return 8'd96;  9'h04E: return 8'd45;  9'h055: return 8'd61;
      9'h054: return 8'd91;  9'h05B: return 8'd93;  9'h05D: return 8'd92;  9'h04C: return 8'd59;
      9'h052: return 8'd39;  9'h041: return 8'd44;  9'h049: return 8'd46;  9'h04A: return 8'd47;
      9'h05A: return 8'd128; 9'h066: return 8'd129; 9'h076: return 8'd140;
      9'h16B: return 8'd130; 9'h175: return 8'd131; 9'h174: return 8'd132; 9'h172: return 8'd133;
      9'h16C: return 8'd134; 9'h169: return 8'd135; 9'h17D: return 8'd136; 9'h17A: return 8'd137;
      9'h170: return 8'd138; 9'h171: return 8'd139;
      9'h005: return 8'd141; 9'h006: return 8'd142; 9'h004: return 8'd143; 9'h00C: return 8'd144;
      9'h003: return 8'd145; 9'h00B: return 8'd146; 9'h083: return 8'd147; 9'h00A: return 8'd148;
      9'h001: return 8'd149; 9'h009: return 8'd150; 9'h078: return 8'd151; 9'h007: return 8'd152;
      default: return 8'd0;
    endcase
  endfunction
`ifdef PS2_PARITY_CHECK_EN
  assign parity_ok = ^{dat_s2_q, shift_q};
`else
  assign parity_ok = 1'b1;
`endif
  always_comb begin
    flip   = (clk_s2_q != filt_q) && (fcnt_q == FW'(FILTER_LEN - 1));
    fcnt_d = (clk_s2_q == filt_q || flip) ? '0 : fcnt_q + 1'b1;
    filt_d = flip ? ~filt_q : filt_q;
    fall   = flip && filt_q;
    // A pending E0/F0 prefix also ages out, so a lone prefix cannot stick forever
    busy   = (state_q != IDLE) || ext_q || brk_q;
    tout   = busy && !fall && (tcnt_q == TW'(TIMEOUT_CYCLES - 1));
    tcnt_d = (!busy || fall || tout) ? '0 : tcnt_q + 1'b1;
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    par_ok_d = par_ok_q;
    bv_d     = 1'b0;
    drop     = 1'b0;
    if (tout) state_d = IDLE;
    else if (fall) begin
      case (state_q)
        IDLE: begin
          state_d  = dat_s2_q ? IDLE : DATA;
          bitcnt_d = '0;
        end
        DATA: begin
          shift_d  = {dat_s2_q, shift_q[7:1]};
          bitcnt_d = bitcnt_q + 1'b1;
          state_d  = (bitcnt_q == 3'd7) ? PARITY : DATA;
        end
        PARITY: begin
          par_ok_d = parity_ok;
          state_d  = STOP;
        end
        default: begin
          bv_d    = dat_s2_q && par_ok_q;
          drop    = dat_s2_q && !par_ok_q;
          state_d = IDLE;
        end
      endcase
    end
  end
  always_comb begin
    code  = lut({ext_q, shift_q});
    ext_d = (tout || drop) ? 1'b0 : ext_q;
    brk_d = (tout || drop) ? 1'b0 : brk_q;
    out_d = out_q;
    if (bv_q) begin
      ext_d = (shift_q == 8'hE0) ? 1'b1 : (shift_q == 8'hF0) ? ext_q : 1'b0;
      brk_d = (shift_q == 8'hF0) ? 1'b1 : (shift_q == 8'hE0) ? brk_q : 1'b0;
      if (shift_q != 8'hE0 && shift_q != 8'hF0)
        out_d = !brk_q ? ((code != 8'd0) ? code : out_q) : ((code == out_q) ? 8'd0 : out_q);
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_s1_q <= 1'b1;
      clk_s2_q <= 1'b1;
      dat_s1_q <= 1'b1;
      dat_s2_q <= 1'b1;
      filt_q   <= 1'b1;
      fcnt_q   <= '0;
      tcnt_q   <= '0;
      state_q  <= IDLE;
      bitcnt_q <= '0;
      shift_q  <= '0;
      par_ok_q <= 1'b0;
      bv_q     <= 1'b0;
      ext_q    <= 1'b0;
      brk_q    <= 1'b0;
      out_q    <= '0;
    end else begin
      clk_s1_q <= kbd.ps2_clk;
      clk_s2_q <= clk_s1_q;
      dat_s1_q <= kbd.ps2_data;
      dat_s2_q <= dat_s1_q;
      filt_q   <= filt_d;
      fcnt_q   <= fcnt_d;
      tcnt_q   <= tcnt_d;
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      shift_q  <= shift_d;
      par_ok_q <= par_ok_d;
      bv_q     <= bv_d;
      ext_q    <= ext_d;
      brk_q    <= brk_d;
      out_q    <= out_d;
    end
  end
  assign kbd.out = {8'h00, out_q};
endmodule
